// File: rtl/mem_acc.sv
`default_nettype none
// =============================================================================
// mem_acc : single-port word-organised data memory for the memory stage.
//           Zero-fills the array after reset, then serves 32-bit reads/writes.
// Revision : 1.0
// =============================================================================
module mem_acc #(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [AW-1:0] addr,
  input  logic          write_enable,
  input  logic [31:0]   data_in,
  output logic          data_out_v,
  output logic [31:0]   data_out,
  output logic          ready
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] PTR_LAST = IW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [31:0]   dout_q, dout_d;
  logic          dout_v_q, dout_v_d;

  logic [31:0]   mem_q [DEPTH];
  logic          mem_we;
  logic [IW-1:0] mem_widx;
  logic [31:0]   mem_wdata;

  logic [IW-1:0] idx;
  logic          unused_addr;

  // Byte offset and bits above the array size are discarded: aligned, wrapping.
  assign idx         = addr[IW+1:2];
  assign unused_addr = ^addr;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    dout_d    = dout_q;
    dout_v_d  = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = ptr_q;
    mem_wdata = 32'h0;

    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (enable) begin
          if (write_enable) begin
            mem_we    = 1'b1;
            mem_widx  = idx;
            mem_wdata = data_in;
          end else begin
            dout_d   = mem_q[idx];
            dout_v_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_CLEAR;
      ptr_q    <= '0;
      dout_q   <= 32'h0;
      dout_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      dout_q   <= dout_d;
      dout_v_q <= dout_v_d;
    end
  end

  // The array itself carries no reset; the clear sequence zero-fills it.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  assign data_out   = dout_q;
  assign data_out_v = dout_v_q;
  assign ready      = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_mem_acc.sv
`default_nettype none
// tb_mem_acc : scoreboard bench for mem_acc (small DEPTH for short clear phase).
module tb_mem_acc;

  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam int IW    = $clog2(DEPTH);

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [AW-1:0] addr;
  logic          write_enable;
  logic [31:0]   data_in;
  logic          data_out_v;
  logic [31:0]   data_out;
  logic          ready;

  mem_acc #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .addr         (addr),
    .write_enable (write_enable),
    .data_in      (data_in),
    .data_out_v   (data_out_v),
    .data_out     (data_out),
    .ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q [$];
  logic        m_ready = 1'b0;
  int          m_cnt   = 0;
  logic        m_dv    = 1'b0;
  logic [31:0] m_dout  = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle, updates the reference model, then checks outputs after the edge.
  task automatic cyc(input logic rn, input logic en, input logic we,
                     input logic [31:0] a, input logic [31:0] d);
    logic [IW-1:0] ix;
    rst_n        = rn;
    enable       = en;
    write_enable = we;
    addr         = a;
    data_in      = d;
    ix           = a[IW+1:2];
    if (!rn) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      m_dv    = 1'b0;
      m_dout  = 32'h0;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    end else if (!m_ready) begin
      m_dv = 1'b0;
      m_cnt++;
      if (m_cnt == DEPTH) m_ready = 1'b1;
    end else if (en && we) begin
      model_mem[ix] = d;
      m_dv          = 1'b0;
    end else if (en) begin
      exp_q.push_back(model_mem[ix]);
      m_dv = 1'b1;
    end else begin
      m_dv = 1'b0;
    end
    @(posedge clk);
    #1;
    check("ready", {31'h0, ready}, {31'h0, m_ready});
    check("data_out_v", {31'h0, data_out_v}, {31'h0, m_dv});
    if (m_dv) begin
      if (exp_q.size() == 0) begin
        check("sb_nonempty", 32'(exp_q.size()), 32'd1);
      end else begin
        m_dout = exp_q.pop_front();
      end
    end
    check(m_dv ? "rd_data" : "data_hold", data_out, m_dout);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; write_enable = 1'b0; addr = '0; data_in = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'hx;

    // Reset with requests present, which must be ignored.
    cyc(1'b0, 1'b1, 1'b1, 32'd4, 32'h1111_1111);
    cyc(1'b0, 1'b1, 1'b0, 32'd4, 32'h0);

    // Clear phase: ready must stay low exactly DEPTH cycles; requests dropped.
    for (int i = 0; i < DEPTH + 2; i++)
      cyc(1'b1, (i % 3) == 0, i[0], 32'(i * 4), 32'hDEAD_0000 + 32'(i));

    cyc(1'b1, 1'b1, 1'b1, 32'd4, 32'hABCD_ABCD);
    cyc(1'b1, 1'b1, 1'b0, 32'd4, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'd8, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 32'd8, 32'hCDEF_CDEF);
    cyc(1'b1, 1'b1, 1'b0, 32'd8, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'd4, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h6, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'(DEPTH * 4 + 4), 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'd8, 32'h5555_5555);
    cyc(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678);
    cyc(1'b1, 1'b1, 1'b0, 32'h0000_003F, 32'h0);

    for (int i = 0; i < 60; i++)
      cyc(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          $urandom, $urandom);

    // Reset in the middle of a read, then requests during the clear sequence.
    cyc(1'b1, 1'b1, 1'b1, 32'd4, 32'h7777_7777);
    cyc(1'b0, 1'b1, 1'b0, 32'd4, 32'h0);
    for (int i = 0; i < DEPTH + 1; i++)
      cyc(1'b1, 1'b1, (i % 2) == 0, 32'd4, 32'hBEEF_0000 + 32'(i));
    cyc(1'b1, 1'b1, 1'b0, 32'd4, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'd8, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'h0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_acc.md
Name: mem_acc

Overview:
- Single-port, word-organised data memory access block for the core's memory stage.
- Accepts byte addresses and performs one 32-bit read or write per enabled clock cycle.
- Returns read data registered one cycle later with a valid flag.
- After reset it runs an internal clear sequence that zero-fills the array before accepting requests.

Parameters:
- DEPTH, 256: number of 32-bit words; power of two, at least 4.
- AW, 32: byte-address width.

Ports:
- clk  input  1  system clock; all activity on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- enable  input  1  request strobe; a request is taken on a rising edge when enable=1 and ready=1.
- addr  input  AW  byte address.
- write_enable  input  1  1 = write request, 0 = read request.
- data_in  input  32  write data.
- data_out_v  output  1  read data valid.
- data_out  output  32  read data.
- ready  output  1  block accepts requests (clear sequence finished).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - data_out_v=0, data_out=0, ready=0.
  - Clear pointer reset to 0; state goes to CLEAR.
  - Requests presented during reset are ignored.
- States:
  - CLEAR: writes 0 to word[ptr] each cycle and increments ptr. After word DEPTH-1 is written, move to RUN and set ready=1 on that same edge. This takes exactly DEPTH cycles after reset is released.
  - RUN: services requests. It stays in RUN until the next reset.
- Address mapping:
  - Word index = addr[log2(DEPTH)+1:2].
  - addr[1:0] are ignored: all accesses are word-aligned, with no misalignment fault.
  - Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Write (RUN, enable=1, write_enable=1 at an edge):
  - word[index] <= data_in.
  - data_out_v <= 0; data_out holds its previous value.
- Read (RUN, enable=1, write_enable=0 at an edge):
  - data_out <= word[index], where word[index] is the array contents before this edge.
  - data_out_v <= 1.
  - Latency: one cycle. Data is stable after the edge that sampled the request, until the next edge.
- Idle (RUN with enable=0, or any cycle in CLEAR):
  - data_out_v <= 0; data_out holds.
  - A request presented while ready=0 is dropped, not queued.
- Back-to-back:
  - A write followed by a read of the same word on the next cycle returns the new data.
  - A read followed by a read gives data_out_v=1 on consecutive cycles.
- data_out_v is a one-cycle pulse per read. There is no backpressure; the consumer must capture data while data_out_v=1.
- Reset mid-operation: outputs cleared on the next edge, and the clear sequence restarts from word 0. Array contents are all zero once ready rises again.
- No X propagation: data_out is never driven from an uninitialised word after reset.

Test Plan:
- Reset clear: hold rst_n=0 for 2 cycles, release, enable=0 -> ready=0 for exactly DEPTH cycles, then 1; data_out_v=0 throughout; data_out=0.
- Write then read: addr=4, write_enable=1, data_in=0xABCDABCD for one cycle, then read addr=4 -> after the write edge data_out_v=0; after the read edge data_out_v=1, data_out=0xABCDABCD.
- Unwritten location: read addr=8 -> data_out_v=1, data_out=0x00000000.
- Write/read of a second word: write 0xCDEFCDEF to addr=8 (data_out_v=0, data_out unchanged), read addr=8 -> 0xCDEFCDEF; re-read addr=4 -> still 0xABCDABCD.
- Alignment and wrap: read addr=0x6 -> same as addr=4; read addr=DEPTH*4+4 -> 0xABCDABCD; enable=0 for one cycle -> data_out_v=0, data_out held.
- Reset mid-run:
  - Assert rst_n=0 during a read -> next edge data_out_v=0, data_out=0.
  - After release, requests during CLEAR are ignored.
  - After ready=1, read addr=4 -> 0x00000000.
